// File: rtl/alu_serial_pkg.sv
// alu_serial_pkg: FSM state encoding and ALU control codes for the bit-serial ALU sequencer
package alu_serial_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam logic [3:0] CTRL_OR   = 4'b0000;
  localparam logic [3:0] CTRL_AND  = 4'b0001;
  localparam logic [3:0] CTRL_ADD  = 4'b0010;
  localparam logic [3:0] CTRL_SUB  = 4'b0110;
  localparam logic [3:0] CTRL_SLT  = 4'b0111;
  localparam logic [3:0] CTRL_NOR  = 4'b1101;
  localparam logic [3:0] CTRL_NAND = 4'b1100;
  localparam logic [1:0] OP_SUM    = 2'b10;
  localparam logic [1:0] OP_LESS   = 2'b11;
endpackage

// File: rtl/ALU_1bit.sv
// ALU_1bit: one-bit ALU slice with operand inversion, OR/AND/sum/less select and carry out
module ALU_1bit (
  input  logic       src1_i,
  input  logic       src2_i,
  input  logic       less_i,
  input  logic       a_invert_i,
  input  logic       b_invert_i,
  input  logic       cin_i,
  input  logic [1:0] operation_i,
  output logic       result_o,
  output logic       cout_o
);
  logic a, b;
  assign a = src1_i ^ a_invert_i;
  assign b = src2_i ^ b_invert_i;
  assign cout_o = (a & b) | (cin_i & (a ^ b));
  assign result_o = operation_i == 2'b00 ? a | b :
                    operation_i == 2'b01 ? a & b :
                    operation_i == 2'b10 ? a ^ b ^ cin_i : less_i;
endmodule

// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: bit-serial ALU sequencer driving one ALU_1bit slice LSB-first over WIDTH cycles.
// Define ALU_SERIAL_FLAGS_EN to add the cout_o/overflow_o flag ports.
module alu_serial_ctrl
  import alu_serial_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       alu_ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o
`ifdef ALU_SERIAL_FLAGS_EN
  , output logic           cout_o
  , output logic           overflow_o
`endif
);
  state_t             state_q;
  logic [WIDTH-1:0]   a_q, b_q, res_q, shift_d, res_d;
  logic [3:0]         ctrl_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               carry_q, busy_q, done_q, zero_q;
  logic               s_res, s_cout, last, is_slt, ovf;
`ifdef ALU_SERIAL_FLAGS_EN
  logic               cout_q, ovf_q;
  assign cout_o     = cout_q;
  assign overflow_o = ovf_q;
`endif
  always_comb begin
    last    = cnt_q == CNT_W'(WIDTH - 1);
    is_slt  = ctrl_q[1:0] == OP_LESS;
    ovf     = carry_q ^ s_cout;
    shift_d = {s_res, res_q[WIDTH-1:1]};
    res_d   = is_slt ? {{(WIDTH-1){1'b0}}, s_res ^ ovf} : shift_d;
  end
  // SLT runs through the slice as a subtract; the sign fix-up is applied on the last bit
  ALU_1bit u_slice (
    .src1_i     (a_q[0]),
    .src2_i     (b_q[0]),
    .less_i     (1'b0),
    .a_invert_i (ctrl_q[3]),
    .b_invert_i (ctrl_q[2]),
    .cin_i      (carry_q),
    .operation_i(is_slt ? OP_SUM : ctrl_q[1:0]),
    .result_o   (s_res),
    .cout_o     (s_cout)
  );
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      ctrl_q  <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      zero_q  <= 1'b0;
`ifdef ALU_SERIAL_FLAGS_EN
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          a_q     <= src1_i;
          b_q     <= src2_i;
          ctrl_q  <= alu_ctrl_i;
          carry_q <= alu_ctrl_i[2];
          cnt_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= RUN;
        end
        RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= s_cout;
          cnt_q   <= cnt_q + CNT_W'(1);
          res_q   <= last ? res_d : shift_d;
          if (last) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            zero_q  <= res_d == '0;
`ifdef ALU_SERIAL_FLAGS_EN
            cout_q  <= s_cout;
            ovf_q   <= ctrl_q[1] & ovf;
`endif
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = res_q;
  assign zero_o   = zero_q;
endmodule

// File: tb/tb_alu_serial_ctrl.sv
// tb_alu_serial_ctrl: table-driven and randomized self-checking bench for alu_serial_ctrl (WIDTH=32)
module tb_alu_serial_ctrl;
  localparam int W = 32;
  localparam logic [3:0] C_OR = 4'b0000, C_AND = 4'b0001, C_ADD = 4'b0010, C_SUB = 4'b0110;
  localparam logic [3:0] C_SLT = 4'b0111, C_NOR = 4'b1101, C_NAND = 4'b1100;
  logic clk = 0, rst_i = 0, start_i = 0;
  logic [3:0] alu_ctrl_i = '0;
  logic [W-1:0] src1_i = '0, src2_i = '0, result_o;
  logic busy_o, done_o, zero_o;
`ifdef ALU_SERIAL_FLAGS_EN
  logic cout_o, overflow_o;
`endif
  int checks = 0, errors = 0;
  typedef struct {logic [3:0] c; logic [W-1:0] a, b, r;} vec_t;
  vec_t tbl[10];
  logic [3:0] codes[7] = '{C_OR, C_AND, C_ADD, C_SUB, C_SLT, C_NOR, C_NAND};

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .alu_ctrl_i(alu_ctrl_i),
    .src1_i(src1_i), .src2_i(src2_i), .busy_o(busy_o), .done_o(done_o),
    .result_o(result_o), .zero_o(zero_o)
`ifdef ALU_SERIAL_FLAGS_EN
    , .cout_o(cout_o), .overflow_o(overflow_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_res(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    case (c)
      C_OR:    return a | b;
      C_AND:   return a & b;
      C_ADD:   return a + b;
      C_SUB:   return a - b;
      C_SLT:   return ($signed(a) < $signed(b)) ? 1 : 0;
      C_NOR:   return ~(a | b);
      C_NAND:  return ~(a & b);
      default: return 'x;
    endcase
  endfunction

  function automatic logic ref_cout(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = c[2] ? {1'b0, a} + {1'b0, ~b} + 1 : {1'b0, a} + {1'b0, b};
    return s[W];
  endfunction

  function automatic logic ref_ovf(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] d;
    if (!c[1]) return 1'b0;
    d = c[2] ? a - b : a + b;
    return c[2] ? (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]) : (a[W-1] == b[W-1]) && (d[W-1] != a[W-1]);
  endfunction

  task automatic run_op(input string nm, input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp);
    int n = 0;
    start_i = 1; alu_ctrl_i = c; src1_i = a; src2_i = b;
    tick();
    start_i = 0;
    src1_i = $urandom;
    src2_i = $urandom;
    chk({nm, " busy"}, W'(busy_o), W'(1));
    while (!done_o && n < 100) begin
      tick();
      n++;
    end
    chk({nm, " latency"}, W'(n), W'(W));
    chk({nm, " result"}, result_o, exp);
    chk({nm, " zero"}, W'(zero_o), W'(exp == 0));
`ifdef ALU_SERIAL_FLAGS_EN
    if (c[1]) chk({nm, " cout"}, W'(cout_o), W'(ref_cout(c, a, b)));
    chk({nm, " ovf"}, W'(overflow_o), W'(ref_ovf(c, a, b)));
`endif
    tick();
    chk({nm, " done pulse"}, W'({done_o, busy_o}), W'(0));
    chk({nm, " held"}, result_o, exp);
  endtask

  initial begin
    int n, first, lastd, cnt;
    tbl[0] = '{C_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000};
    tbl[1] = '{C_SUB,  32'd5,        32'd5,        32'h0};
    tbl[2] = '{C_SUB,  32'd0,        32'd1,        32'hFFFFFFFF};
    tbl[3] = '{C_SLT,  32'h80000000, 32'h00000001, 32'h1};
    tbl[4] = '{C_SLT,  32'd3,        32'd3,        32'h0};
    tbl[5] = '{C_AND,  32'hF0F0A5A5, 32'h0FF0FFFF, 32'h00F0A5A5};
    tbl[6] = '{C_OR,   32'hF0F0A5A5, 32'h0FF0FFFF, 32'hFFF0FFFF};
    tbl[7] = '{C_NOR,  32'hF0F0A5A5, 32'h0FF0FFFF, 32'h000F0000};
    tbl[8] = '{C_NAND, 32'hF0F0A5A5, 32'h0FF0FFFF, 32'hFF0F5A5A};
    tbl[9] = '{C_SLT,  32'h00000001, 32'h80000000, 32'h0};
    tick(); tick();
    chk("reset state", {result_o[W-4:0], busy_o, done_o, zero_o}, '0);
    rst_i = 1;
    tick();
    for (int i = 0; i < 10; i++) run_op($sformatf("vec%0d", i), tbl[i].c, tbl[i].a, tbl[i].b, tbl[i].r);
    for (int i = 0; i < 40; i++) begin
      logic [3:0] c;
      logic [W-1:0] a, b;
      c = codes[$urandom_range(0, 6)];
      a = $urandom;
      b = (i % 8 == 0) ? a : $urandom;
      run_op($sformatf("rnd%0d", i), c, a, b, ref_res(c, a, b));
    end
    // start held high: one done per W+2 cycles
    start_i = 1; alu_ctrl_i = C_ADD; src1_i = 32'd1; src2_i = 32'd2;
    tick();
    cnt = 0; first = -1; lastd = -1;
    for (n = 1; n <= 3 * (W + 2); n++) begin
      tick();
      if (done_o) begin
        cnt++;
        if (first < 0) begin
          first = n;
          chk("held result", result_o, 32'd3);
        end
        lastd = n;
      end
    end
    start_i = 0;
    chk("held done count", W'(cnt), W'(3));
    chk("held first done", W'(first), W'(W));
    chk("held spacing", W'(lastd - first), W'(2 * (W + 2)));
    n = 0;
    while (busy_o && n < 60) begin
      tick();
      n++;
    end
    chk("held drain", W'(busy_o), W'(0));
    // reset mid-run aborts without done
    start_i = 1; alu_ctrl_i = C_OR; src1_i = 32'hFFFF0000; src2_i = 32'h0000FFFF;
    tick();
    start_i = 0;
    for (int i = 0; i < 10; i++) tick();
    rst_i = 0;
    tick();
    rst_i = 1;
    chk("abort state", {result_o[W-4:0], busy_o, done_o, zero_o}, '0);
    tick();
    chk("abort no done", W'({done_o, busy_o}), W'(0));
    run_op("after abort", C_ADD, 32'd3, 32'd4, 32'd7);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
